qcw_burst_ctrl: RTL and testbench
=================================

Name: qcw_burst_ctrl

Overview:
Burst sequencer that drives the QCW PLL's control interface.
- On a trigger, it starts one PLL burst and sets the cycle limit.
- During the burst, it ramps phase_shift from a start value to an end value, one step per N completed PLL cycles.
- It watches the PLL's done and fault outputs, enforces a minimum off-time between bursts, and locks out after a fault.
- Sits between the host/register block and qcw_pll.

Parameters:
HOLDOFF_CLKS, 24'd1000000, minimum clk cycles from burst end to the next accepted trigger
WATCHDOG_CLKS, 16'd4000, maximum clk cycles between pll_cycle_finished pulses while running
CNT_W, 16, width of burst_count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
trigger  in  1  burst request, sampled in IDLE only
abort  in  1  request early stop of the running burst
fault_clear  in  1  leaves LOCKOUT
burst_cycles  in  16  PLL cycles per burst; 0 = trigger ignored
phase_start  in  8  initial phase_shift
phase_end  in  8  saturation phase_shift
ramp_step  in  8  phase increment per ramp tick
ramp_div  in  8  cycle_finished pulses per ramp tick; 0 treated as 1
pll_start  out  1  one-clk start pulse to PLL
pll_halt  out  1  halt level to PLL
pll_phase_shift  out  8  phase to PLL
pll_cycle_limit  out  16  cycle limit to PLL
pll_cycle_finished  in  1  one-clk pulse per PLL period
pll_done  in  1  PLL done (sticky level)
pll_fault  in  1  PLL fault (sticky level)
busy  out  1  high in every state except IDLE
fault_latched  out  1  high in LOCKOUT
timeout  out  1  LOCKOUT was entered via watchdog
burst_count  out  CNT_W  bursts completed normally; wraps

Behaviour:
- Reset: every output is 0; state is IDLE; pll_done and pll_fault edge registers are cleared to 0.
- Edge detection: pll_done and pll_fault are sticky levels until the next start, so only rising edges (registered previous value) are acted on.
- IDLE:
  - Condition: trigger && burst_cycles!=0.
  - Actions: pll_cycle_limit<=burst_cycles, pll_phase_shift<=phase_start, ramp divider<=0, watchdog<=0.
  - Next cycle: pll_start=1 for exactly 1 clk, go RUN.
- RUN:
  - Each pll_cycle_finished increments the divider and clears the watchdog.
  - When divider reaches max(ramp_div,1)-1, divider<=0 and phase<=min(phase+ramp_step, phase_end), using a 9-bit sum.
  - If phase_start>phase_end, phase holds at phase_start.
- RUN exits, in priority order (highest first):
  - pll_fault rise: go LOCKOUT.
  - pll_done rise: burst_count++, go HOLDOFF.
  - watchdog reaches WATCHDOG_CLKS: timeout<=1, pll_halt<=1, go LOCKOUT.
  - abort: pll_halt<=1, go HALTING.
- HALTING:
  - pll_halt is held at 1.
  - pll_fault rise or pll_done rise: pll_halt<=0, go HOLDOFF. This is not a fault, and burst_count is unchanged.
- HOLDOFF:
  - Counts HOLDOFF_CLKS clocks, then goes IDLE.
  - trigger is ignored and not queued.
- LOCKOUT:
  - fault_latched=1.
  - fault_clear: clears fault_latched, timeout and pll_halt, go IDLE.
- Ramp and pll_phase_shift stay frozen outside RUN.
- rst mid-burst: immediate return to IDLE with all outputs at 0.

Optional Feature:
QCW_BURST_WATCHDOG_EN
- Defined: watchdog as described above.
- Undefined: no watchdog counter; timeout is tied to 0; RUN exits only on fault, done or abort.

Decomposition:
- qcw_pkg: state localparams (IDLE, RUN, HALTING, HOLDOFF, LOCKOUT) and PHASE_W=8, CYC_W=16.
- One sub-module, qcw_phase_ramp:
  - Contains the divider and the saturating phase accumulator.
  - Inputs: load, tick, start/end/step/div.
  - Output: phase.

Test Plan:
1. burst_cycles=20, phase_start=10, step=5, div=2, end=40; model asserts done after 20 cycle_finished pulses -> phase sequence 10,15,20,…,40 saturating; one pll_start pulse; burst_count=1; IDLE after HOLDOFF_CLKS.
2. trigger held high continuously -> exactly one pll_start per burst+HOLDOFF_CLKS interval; no start during HOLDOFF.
3. abort at cycle 5, model raises fault -> pll_halt high until fault edge, then HOLDOFF; fault_latched=0; burst_count unchanged.
4. model raises fault at cycle 7 unprovoked -> LOCKOUT, fault_latched=1; triggers ignored until fault_clear, then a new burst starts.
5. cycle_finished stops for WATCHDOG_CLKS -> timeout=1, pll_halt=1, LOCKOUT. Without macro: no timeout.
6. pll_done stale high from the previous burst while a new burst starts -> no early exit until a fresh rising edge. Also: rst mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/qcw_pkg.sv
// Shared types and widths for the QCW burst sequencer.
package qcw_pkg;
  localparam int PHASE_W = 8;
  localparam int CYC_W   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    HALTING = 3'd2,
    HOLDOFF = 3'd3,
    LOCKOUT = 3'd4
  } state_t;
endpackage

// File: rtl/qcw_phase_ramp.sv
// Phase ramp: divides cycle_finished ticks by ramp_div, then steps the phase
// toward phase_end with a 9-bit saturating sum.
module qcw_phase_ramp
  import qcw_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               tick,
  input  logic [PHASE_W-1:0] phase_start,
  input  logic [PHASE_W-1:0] phase_end,
  input  logic [PHASE_W-1:0] ramp_step,
  input  logic [PHASE_W-1:0] ramp_div,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] div_cnt;
  logic [PHASE_W-1:0] div_last;
  logic [PHASE_W:0]   sum;

  assign div_last = (ramp_div == '0) ? '0 : ramp_div - PHASE_W'(1);
  assign sum      = {1'b0, phase} + {1'b0, ramp_step};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (load) begin
      div_cnt <= '0;
      phase   <= phase_start;
    end else if (tick) begin
      // >= keeps the divider from running away if ramp_div shrinks mid-burst
      if (div_cnt >= div_last) begin
        div_cnt <= '0;
        if (phase_start <= phase_end)
          phase <= (sum > {1'b0, phase_end}) ? phase_end : sum[PHASE_W-1:0];
      end else begin
        div_cnt <= div_cnt + PHASE_W'(1);
      end
    end
  end

endmodule

// File: rtl/qcw_burst_ctrl.sv
// QCW burst sequencer between the register block and qcw_pll.
// Optional watchdog on the RUN state: define QCW_BURST_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | waiting for trigger with nonzero burst_cycles
// RUN     | PLL burst active, phase ramp advancing
// HALTING | abort requested, pll_halt held until PLL reports done/fault
// HOLDOFF | enforced off-time, triggers dropped
// LOCKOUT | fault or watchdog latched, waits for fault_clear
module qcw_burst_ctrl
  import qcw_pkg::*;
#(
  parameter logic [23:0] HOLDOFF_CLKS  = 24'd1000000,
  parameter logic [15:0] WATCHDOG_CLKS = 16'd4000,
  parameter int          CNT_W         = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic               abort,
  input  logic               fault_clear,
  input  logic [CYC_W-1:0]   burst_cycles,
  input  logic [PHASE_W-1:0] phase_start,
  input  logic [PHASE_W-1:0] phase_end,
  input  logic [PHASE_W-1:0] ramp_step,
  input  logic [PHASE_W-1:0] ramp_div,
  output logic               pll_start,
  output logic               pll_halt,
  output logic [PHASE_W-1:0] pll_phase_shift,
  output logic [CYC_W-1:0]   pll_cycle_limit,
  input  logic               pll_cycle_finished,
  input  logic               pll_done,
  input  logic               pll_fault,
  output logic               busy,
  output logic               fault_latched,
  output logic               timeout,
  output logic [CNT_W-1:0]   burst_count
);

  state_t      state;
  logic        done_q;
  logic        fault_q;
  logic        done_rise;
  logic        fault_rise;
  logic        ramp_load;
  logic        ramp_tick;
  logic        wd_expired;
  logic [23:0] hold_cnt;

  // done/fault stay high until the next start, so only fresh edges count
  assign done_rise  = pll_done  & ~done_q;
  assign fault_rise = pll_fault & ~fault_q;
  assign ramp_load  = (state == IDLE) && trigger && (burst_cycles != '0);
  assign ramp_tick  = (state == RUN) && pll_cycle_finished;

`ifdef QCW_BURST_WATCHDOG_EN
  logic [15:0] wd_rem;

  assign wd_expired = (wd_rem == '0);

  always_ff @(posedge clk) begin
    if (rst)
      wd_rem <= WATCHDOG_CLKS;
    else if (ramp_load || pll_cycle_finished)
      wd_rem <= WATCHDOG_CLKS;
    else if ((state == RUN) && !wd_expired)
      wd_rem <= wd_rem - 16'd1;
  end
`else
  logic wd_unused;

  assign wd_unused  = ^WATCHDOG_CLKS;
  assign wd_expired = 1'b0;
`endif

  qcw_phase_ramp u_ramp (
    .clk         (clk),
    .rst         (rst),
    .load        (ramp_load),
    .tick        (ramp_tick),
    .phase_start (phase_start),
    .phase_end   (phase_end),
    .ramp_step   (ramp_step),
    .ramp_div    (ramp_div),
    .phase       (pll_phase_shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
      hold_cnt        <= '0;
      pll_start       <= 1'b0;
      pll_halt        <= 1'b0;
      pll_cycle_limit <= '0;
      busy            <= 1'b0;
      fault_latched   <= 1'b0;
      timeout         <= 1'b0;
      burst_count     <= '0;
    end else begin
      done_q    <= pll_done;
      fault_q   <= pll_fault;
      pll_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ramp_load) begin
            pll_cycle_limit <= burst_cycles;
            pll_start       <= 1'b1;
            busy            <= 1'b1;
            state           <= RUN;
          end
        end
        RUN: begin
          if (fault_rise) begin
            fault_latched <= 1'b1;
            state         <= LOCKOUT;
          end else if (done_rise) begin
            burst_count <= burst_count + CNT_W'(1);
            hold_cnt    <= HOLDOFF_CLKS - 24'd1;
            state       <= HOLDOFF;
          end else if (wd_expired) begin
            timeout       <= 1'b1;
            pll_halt      <= 1'b1;
            fault_latched <= 1'b1;
            state         <= LOCKOUT;
          end else if (abort) begin
            pll_halt <= 1'b1;
            state    <= HALTING;
          end
        end
        HALTING: begin
          if (fault_rise || done_rise) begin
            pll_halt <= 1'b0;
            hold_cnt <= HOLDOFF_CLKS - 24'd1;
            state    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 24'd1;
          end
        end
        LOCKOUT: begin
          if (fault_clear) begin
            fault_latched <= 1'b0;
            timeout       <= 1'b0;
            pll_halt      <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qcw_burst_ctrl.sv
// Self-checking bench for qcw_burst_ctrl; models the PLL side and predicts
// ramp phase, counts and timing from the burst rules.
module tb_qcw_burst_ctrl;
  localparam logic [23:0] HOLD = 24'd30;
  localparam logic [15:0] WD   = 16'd40;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger, abort, fault_clear;
  logic [15:0] burst_cycles;
  logic [7:0]  phase_start, phase_end, ramp_step, ramp_div;
  logic        pll_start, pll_halt;
  logic [7:0]  pll_phase_shift;
  logic [15:0] pll_cycle_limit;
  logic        pll_cycle_finished, pll_done, pll_fault;
  logic        busy, fault_latched, timeout;
  logic [15:0] burst_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  qcw_burst_ctrl #(.HOLDOFF_CLKS(HOLD), .WATCHDOG_CLKS(WD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .fault_clear(fault_clear),
    .burst_cycles(burst_cycles), .phase_start(phase_start), .phase_end(phase_end),
    .ramp_step(ramp_step), .ramp_div(ramp_div), .pll_start(pll_start), .pll_halt(pll_halt),
    .pll_phase_shift(pll_phase_shift), .pll_cycle_limit(pll_cycle_limit),
    .pll_cycle_finished(pll_cycle_finished), .pll_done(pll_done), .pll_fault(pll_fault),
    .busy(busy), .fault_latched(fault_latched), .timeout(timeout), .burst_count(burst_count)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // phase after n completed PLL cycles, straight from the ramp rules
  function automatic int exp_phase(int ps, int pe, int st, int dv, int n);
    int v;
    if (ps > pe) return ps;
    v = ps + (n / ((dv == 0) ? 1 : dv)) * st;
    return (v > pe) ? pe : v;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_start"}, pll_start, 0);
    check_val({tag, "_halt"}, pll_halt, 0);
    check_val({tag, "_phase"}, pll_phase_shift, 0);
    check_val({tag, "_limit"}, pll_cycle_limit, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_flt"}, fault_latched, 0);
    check_val({tag, "_tmo"}, timeout, 0);
    check_val({tag, "_count"}, burst_count, 0);
  endtask

  task automatic start_burst(input int cyc, input int ps, input int pe, input int st,
                             input int dv, input bit keep_trig);
    burst_cycles = cyc[15:0];
    phase_start  = ps[7:0];
    phase_end    = pe[7:0];
    ramp_step    = st[7:0];
    ramp_div     = dv[7:0];
    trigger      = 1'b1;
    @(negedge clk);
    check_val("start_pulse", pll_start, 1);
    check_val("start_busy", busy, 1);
    check_val("start_limit", pll_cycle_limit, cyc);
    check_val("start_phase", pll_phase_shift, ps);
    if (!keep_trig) trigger = 1'b0;
    @(negedge clk);
    check_val("start_once", pll_start, 0);
  endtask

  task automatic run_pulses(input int n, input int gmax, input int ps, input int pe,
                            input int st, input int dv);
    for (int i = 1; i <= n; i++) begin
      int gap;
      gap = $urandom_range(gmax - 1, 0);
      repeat (gap) @(negedge clk);
      pll_cycle_finished = 1'b1;
      @(negedge clk);
      pll_cycle_finished = 1'b0;
      check_val("phase", pll_phase_shift, exp_phase(ps, pe, st, dv, i));
    end
  endtask

  // called on the negedge right after the edge that entered HOLDOFF
  task automatic measure_holdoff(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_val(tag, n, HOLD);
  endtask

  task automatic finish_burst();
    pll_done = 1'b1;
    @(negedge clk);
    exp_count++;
    check_val("done_count", burst_count, exp_count);
    check_val("done_busy", busy, 1);
    measure_holdoff("holdoff_len");
    pll_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst = 1'b1; trigger = 0; abort = 0; fault_clear = 0;
    burst_cycles = 0; phase_start = 0; phase_end = 0; ramp_step = 0; ramp_div = 0;
    pll_cycle_finished = 0; pll_done = 0; pll_fault = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // zero burst length never starts
    burst_cycles = 0; trigger = 1'b1;
    repeat (3) @(negedge clk);
    check_val("zero_cyc_start", pll_start, 0);
    check_val("zero_cyc_busy", busy, 0);
    trigger = 1'b0;

    // nominal burst: 10,15,...,40 saturating
    start_burst(20, 10, 40, 5, 2, 0);
    run_pulses(20, 3, 10, 40, 5, 2);
    check_val("t1_phase_end", pll_phase_shift, 40);
    finish_burst();
    check_val("t1_idle_busy", busy, 0);

    // trigger held: restart only after holdoff, then a stale done must not end the burst
    start_burst(6, 0, 100, 7, 1, 1);
    run_pulses(6, 2, 0, 100, 7, 1);
    pll_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pll_start !== 1'b1 && n < 200);
    exp_count++;
    check_val("t2_restart_gap", n, HOLD + 2);
    check_val("t2_count", burst_count, exp_count);
    check_val("t2_restart_phase", pll_phase_shift, 0);
    trigger = 1'b0;
    run_pulses(3, 2, 0, 100, 7, 1);
    check_val("t6_stale_busy", busy, 1);
    check_val("t6_stale_count", burst_count, exp_count);
    pll_done = 1'b0;
    @(negedge clk);
    check_val("t6_low_busy", busy, 1);
    finish_burst();

    // abort then PLL reports fault: clean halt, not a lockout
    start_burst(20, 0, 200, 3, 1, 0);
    run_pulses(5, 2, 0, 200, 3, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("t3_halt", pll_halt, 1);
    repeat (4) @(negedge clk);
    check_val("t3_halt_hold", pll_halt, 1);
    check_val("t3_phase_frozen", pll_phase_shift, 15);
    pll_fault = 1'b1;
    @(negedge clk);
    check_val("t3_halt_off", pll_halt, 0);
    check_val("t3_flt", fault_latched, 0);
    check_val("t3_count", burst_count, exp_count);
    measure_holdoff("t3_holdoff");
    pll_fault = 1'b0;
    @(negedge clk);

    // unprovoked fault: lockout, triggers ignored until cleared
    start_burst(20, 5, 50, 4, 3, 0);
    run_pulses(7, 2, 5, 50, 4, 3);
    pll_fault = 1'b1;
    @(negedge clk);
    check_val("t4_flt", fault_latched, 1);
    check_val("t4_busy", busy, 1);
    trigger = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (pll_start === 1'b1) n++;
    end
    check_val("t4_no_start", n, 0);
    pll_fault = 1'b0;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    check_val("t4_cleared", fault_latched, 0);
    check_val("t4_idle", busy, 0);
    @(negedge clk);
    check_val("t4_restart", pll_start, 1);
    trigger = 1'b0;
    run_pulses(20, 2, 5, 50, 4, 3);
    finish_burst();

    // PLL stops delivering cycles
    start_burst(20, 0, 255, 1, 1, 0);
    run_pulses(2, 2, 0, 255, 1, 1);
`ifdef QCW_BURST_WATCHDOG_EN
    n = 0;
    while (fault_latched !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_wd_delay", n, WD + 1);
    check_val("t5_timeout", timeout, 1);
    check_val("t5_halt", pll_halt, 1);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    check_val("t5_clr_tmo", timeout, 0);
    check_val("t5_clr_halt", pll_halt, 0);
    check_val("t5_clr_busy", busy, 0);
`else
    repeat (WD + 20) @(negedge clk);
    check_val("t5_no_timeout", timeout, 0);
    check_val("t5_no_lock", fault_latched, 0);
    check_val("t5_still_busy", busy, 1);
    finish_burst();
`endif

    // randomized bursts
    for (int k = 0; k < 8; k++) begin
      int cyc, ps, pe, st, dv;
      cyc = $urandom_range(15, 1);
      ps  = $urandom_range(255, 0);
      pe  = $urandom_range(255, 0);
      st  = $urandom_range(40, 0);
      dv  = $urandom_range(3, 0);
      start_burst(cyc, ps, pe, st, dv, 0);
      run_pulses(cyc, 4, ps, pe, st, dv);
      finish_burst();
    end

    // reset in the middle of a burst
    start_burst(20, 10, 90, 9, 1, 0);
    run_pulses(4, 2, 10, 90, 9, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t6_rst");
    rst = 1'b0;
    exp_count = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
